// File: rtl/sram_ctrl.sv
// Sequences cs_n/oe_n/we_n for a 256Kx8 async SRAM from a single cs/we request; all outputs registered.
// Ack lands 2+RD_CYCLES (read) / 2+WR_CYCLES (write) cycles after the request; master holds the request until ack.
module sram_ctrl #(
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 3,
    parameter int TURN_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [1:0]  i_bank,
    input  logic [7:0]  i_dat,
    input  logic        i_we,
    input  logic        i_cs,
    output logic [7:0]  o_dat,
    output logic        o_ack,
    output logic        o_busy,
    output logic [17:0] o_sram_addr,
    output logic [7:0]  o_sram_dat,
    input  logic [7:0]  i_sram_dat,
    output logic        o_sram_drive,
    output logic        o_sram_cs_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES)
                           ? ((RD_CYCLES > TURN_CYCLES) ? RD_CYCLES : TURN_CYCLES)
                           : ((WR_CYCLES > TURN_CYCLES) ? WR_CYCLES : TURN_CYCLES);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        WRITE,
        DONE,
        RECOVER
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            we_q, we_nxt;
    logic            start;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (i_cs) begin
                    state_nxt = SETUP;
                    start     = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = we_q ? WRITE : READ;
                cnt_nxt   = we_q ? CW'(WR_CYCLES - 1) : CW'(RD_CYCLES - 1);
            end
            READ, WRITE: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                state_nxt = RECOVER;
                cnt_nxt   = CW'(TURN_CYCLES - 1);
            end
            RECOVER: begin
                // The last recovery cycle doubles as the idle sample point so
                // back-to-back requests keep the 2+RD/WR+TURN period.
                if (cnt == '0) begin
                    if (i_cs) begin
                        state_nxt = SETUP;
                        start     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        we_nxt = start ? i_we : we_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_dat   <= '0;
            o_dat        <= '0;
            o_ack        <= 1'b0;
            o_busy       <= 1'b0;
            o_sram_cs_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_drive <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            we_q  <= we_nxt;
            if (start) begin
                o_sram_addr <= {i_bank, i_addr};
                o_sram_dat  <= i_dat;
            end
            if (state == READ && cnt == '0) o_dat <= i_sram_dat;
            // Strobes are decoded from the next state so every pin comes straight off a flop.
            o_ack        <= (state_nxt == DONE);
            o_busy       <= (state_nxt != IDLE);
            o_sram_cs_n  <= !(state_nxt inside {SETUP, READ, WRITE, DONE});
            o_sram_oe_n  <= (state_nxt != READ);
            o_sram_we_n  <= (state_nxt != WRITE);
            o_sram_drive <= we_nxt && (state_nxt inside {SETUP, WRITE, DONE});
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboarded bench for sram_ctrl: randomized master traffic against a 256Kx8 SRAM model and an access-level reference.
module tb_sram_ctrl;

    localparam int RD = 2, WR = 3, TURN = 1;
    localparam int B_RD = 1, B_TURN = 3;

    typedef struct {
        bit          wr;
        logic [17:0] addr;
        logic [7:0]  dat;
        int          exp_ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_addr = '0;
    logic [1:0]  i_bank = '0;
    logic [7:0]  i_dat = '0;
    logic        i_we = 1'b0;
    logic        i_cs = 1'b0;
    logic [7:0]  o_dat, o_sram_dat, sram_q;
    logic        o_ack, o_busy, drive, cs_n, oe_n, we_n;
    logic [17:0] o_sram_addr;

    logic [15:0] b_addr = '0;
    logic        b_cs = 1'b0;
    logic [7:0]  b_odat, b_sram_dat, b_sram_q;
    logic        b_ack, b_busy, b_drive, b_cs_n, b_oe_n, b_we_n;
    logic [17:0] b_sram_addr;

    int   tests = 0, fails = 0, cyc = 0, last_ack = -1000;
    exp_t sb[$];
    logic [7:0] ref_mem [logic [17:0]];
    logic [7:0] sram_mem [0:262143];

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_bank(i_bank), .i_dat(i_dat),
        .i_we(i_we), .i_cs(i_cs), .o_dat(o_dat), .o_ack(o_ack), .o_busy(o_busy),
        .o_sram_addr(o_sram_addr), .o_sram_dat(o_sram_dat), .i_sram_dat(sram_q),
        .o_sram_drive(drive), .o_sram_cs_n(cs_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n)
    );

    sram_ctrl #(.RD_CYCLES(B_RD), .WR_CYCLES(3), .TURN_CYCLES(B_TURN)) u_dut_b (
        .i_clk(clk), .i_reset(i_reset), .i_addr(b_addr), .i_bank(2'b00), .i_dat(8'h00),
        .i_we(1'b0), .i_cs(b_cs), .o_dat(b_odat), .o_ack(b_ack), .o_busy(b_busy),
        .o_sram_addr(b_sram_addr), .o_sram_dat(b_sram_dat), .i_sram_dat(b_sram_q),
        .o_sram_drive(b_drive), .o_sram_cs_n(b_cs_n), .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n)
    );

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b100101, a[17:16]};
    endfunction

    function automatic logic [7:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Async SRAM: read while cs_n&oe_n low; a write commits when we_n rises with cs_n still low.
    assign sram_q   = (!cs_n && !oe_n) ? sram_mem[o_sram_addr] : 8'h00;
    assign b_sram_q = b_oe_n ? 8'h00 : (b_sram_addr[7:0] ^ 8'h3C);

    initial begin
        logic        pend;
        logic [17:0] pa;
        logic [7:0]  pd;
        pend = 1'b0;
        pa = '0;
        pd = '0;
        for (int i = 0; i < 262144; i++) sram_mem[i] = init_byte(18'(i));
        forever begin
            @(negedge clk);
            if (cs_n) pend = 1'b0;
            else if (!we_n) begin
                pend = 1'b1;
                pa = o_sram_addr;
                pd = o_sram_dat;
            end else if (drive && pend) begin
                sram_mem[pa] = pd;
                pend = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and watches pin-level rules each cycle.
    initial begin
        exp_t e;
        int   we_run, oe_run, undriven;
        bit   wr_seen, oe_prev;
        logic [7:0] last_rd;
        we_run = 0; oe_run = 0; undriven = 0; wr_seen = 0; oe_prev = 1; last_rd = '0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                we_run = 0; oe_run = 0; wr_seen = 0; oe_prev = 1; last_rd = '0;
            end else begin
                if (!cs_n && sb.size() > 0) begin
                    check("sram_addr", 32'(o_sram_addr), 32'(sb[0].addr));
                    if (drive) check("sram_wdat", 32'(o_sram_dat), 32'(sb[0].dat));
                end
                if (!oe_n && drive) check("oe_low_while_driven", 1, 0);
                if (o_ack) begin
                    if (sb.size() == 0) check("unexpected_ack", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("ack_cycle", cyc, e.exp_ack);
                        if (!e.wr) begin
                            check("rd_data", 32'(o_dat), 32'(e.dat));
                            last_rd = e.dat;
                        end else begin
                            check("dat_held_on_write", 32'(o_dat), 32'(last_rd));
                        end
                    end
                end
                if (!we_n) we_run++;
                else if (we_run > 0) begin
                    check("we_n_width", we_run, WR);
                    we_run = 0;
                end
                if (!oe_n) oe_run++;
                else if (oe_run > 0) begin
                    check("oe_n_width", oe_run, RD);
                    oe_run = 0;
                end
                if (drive) begin
                    wr_seen = 1;
                    undriven = 0;
                end else if (cs_n) undriven++;
                if (!oe_n && oe_prev) begin
                    if (wr_seen) check("turnaround_gap", (undriven >= TURN) ? 1 : 0, 1);
                    wr_seen = 0;
                end
                oe_prev = oe_n;
            end
        end
    end

    // Master: presents a request, records its expected ack cycle, waits for ack.
    task automatic access(input bit wr, input logic [17:0] a, input logic [7:0] d,
                          input bit scramble, output int ack_cyc);
        exp_t e;
        int   n, e0;
        bit   got;
        i_cs = 1'b1; i_we = wr; i_bank = a[17:16]; i_addr = a[15:0]; i_dat = d;
        e0 = (cyc + 1 > last_ack + 1 + TURN) ? cyc + 1 : last_ack + 1 + TURN;
        e.wr = wr;
        e.addr = a;
        e.dat = wr ? d : ref_rd(a);
        e.exp_ack = e0 + 1 + (wr ? WR : RD);
        last_ack = e.exp_ack;
        if (wr) ref_mem[a] = d;
        sb.push_back(e);
        n = 0; got = 0; ack_cyc = -1;
        while (!got && n < 40) begin
            @(negedge clk);
            if (o_ack) begin
                got = 1;
                ack_cyc = cyc;
            end else begin
                n++;
                if (scramble && n == 3) begin
                    i_addr = 16'($urandom);
                    i_dat = 8'($urandom);
                end
            end
        end
        check("ack_seen", got ? 1 : 0, 1);
        if (!got) sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int g);
        i_cs = 1'b0;
        repeat (g) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_b(output int c);
        int n;
        n = 0; c = -1;
        while (c < 0 && n < 40) begin
            @(negedge clk);
            if (b_ack) c = cyc;
            else n++;
        end
        check("b_ack_seen", (c >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int t0, c1, c2, c3, acks, g;
        bit wr, scr;
        logic [17:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 32'({cs_n, oe_n, we_n}), 32'(3'b111));
        check("rst_drive_ack_busy", 32'({drive, o_ack, o_busy}), 32'(3'b000));
        check("rst_o_dat", 32'(o_dat), 32'h00);
        check("rst_sram_addr", 32'(o_sram_addr), 32'h0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        idle(2);

        t0 = cyc;
        access(1, 18'h21234, 8'hA5, 0, c1);
        check("wr_ack_latency", c1 - t0, 5);
        idle(2);
        t0 = cyc;
        access(0, 18'h21234, 8'h00, 0, c1);
        check("rd_ack_latency", c1 - t0, 4);
        check("rd_back_a5", 32'(o_dat), 32'hA5);
        idle(2);

        access(0, 18'h00000, 8'h00, 0, c1);
        access(0, 18'h00001, 8'h00, 0, c2);
        access(0, 18'h00002, 8'h00, 1, c3);
        check("b2b_period_1", c2 - c1, 5);
        check("b2b_period_2", c3 - c2, 5);
        idle(1);

        access(1, 18'h10055, 8'h77, 0, c1);
        access(0, 18'h10055, 8'h00, 0, c2);
        check("wr_rd_period", c2 - c1, 2 + RD + TURN);
        idle(4);

        // Abort a write in its second we_n cycle; the old byte must survive.
        i_cs = 1'b1; i_we = 1'b1; i_bank = 2'd2; i_addr = 16'h1234; i_dat = 8'h3C;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mid_write_we_n", 32'({we_n, drive}), 32'(2'b01));
        i_reset = 1'b1;
        i_cs = 1'b0;
        @(negedge clk);
        check("abort_strobes", 32'({cs_n, oe_n, we_n}), 32'(3'b111));
        check("abort_drive_ack_busy", 32'({drive, o_ack, o_busy}), 32'(3'b000));
        @(posedge clk); #1;
        i_reset = 1'b0;
        last_ack = -1000;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_ack) acks++;
        end
        check("no_ack_after_abort", acks, 0);
        @(posedge clk); #1;
        access(0, 18'h21234, 8'h00, 0, c1);
        check("abort_kept_old", 32'(o_dat), 32'hA5);
        idle(1);

        for (int i = 0; i < 80; i++) begin
            wr = ($urandom % 2) != 0;
            a = {2'($urandom % 4), 16'($urandom % 8)};
            scr = !wr && (($urandom % 2) != 0);
            access(wr, a, 8'($urandom), scr, c1);
            g = $urandom % 3;
            if (g != 0) idle(g);
        end
        idle(6);
        check("scoreboard_drained", sb.size(), 0);

        // Second instance: RD_CYCLES=1, TURN_CYCLES=3.
        t0 = cyc;
        b_cs = 1'b1;
        b_addr = 16'h0040;
        wait_b(c1);
        check("b_ack_latency", c1 - t0, 2 + B_RD);
        check("b_rd_data_0", 32'(b_odat), 32'(8'h40 ^ 8'h3C));
        check("b_pins_at_ack", 32'({b_cs_n, b_we_n, b_drive, b_busy, b_sram_dat}), 32'(12'h500));
        @(posedge clk); #1;
        b_addr = 16'h0041;
        wait_b(c2);
        check("b_period_1", c2 - c1, 2 + B_RD + B_TURN);
        check("b_rd_data_1", 32'(b_odat), 32'(8'h41 ^ 8'h3C));
        @(posedge clk); #1;
        b_addr = 16'h0042;
        wait_b(c3);
        check("b_period_2", c3 - c2, 2 + B_RD + B_TURN);
        check("b_rd_data_2", 32'(b_odat), 32'(8'h42 ^ 8'h3C));
        @(posedge clk); #1;
        b_cs = 1'b0;
        repeat (6) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
